// File: rtl/rsfq_gate_pkg.sv
// Shared definitions for the clocked RSFQ gate: logic modes, the tri-state
// channel encoding and the gate evaluation function.
package rsfq_gate_pkg;

  localparam int MAX_IN   = 16;
  localparam int MODE_AND = 0;
  localparam int MODE_OR  = 1;
  localparam int MODE_XOR = 2;

  typedef enum logic [1:0] {
    S_ZERO = 2'b00,
    S_ONE  = 2'b01,
    S_X    = 2'b10
  } tri_t;

  // Channels at index >= n are ignored; any undefined code is treated as X.
  function automatic tri_t eval_gate(input int mode, input logic [2*MAX_IN-1:0] st,
                                     input int n);
    logic any0;
    logic any1;
    logic anyx;
    logic par;
    tri_t res;
    any0 = 1'b0;
    any1 = 1'b0;
    anyx = 1'b0;
    par  = 1'b0;
    for (int i = 0; i < MAX_IN; i++) begin
      if (i < n) begin
        if (st[2*i +: 2] == S_ZERO) begin
          any0 = 1'b1;
        end else if (st[2*i +: 2] == S_ONE) begin
          any1 = 1'b1;
          par  = ~par;
        end else begin
          anyx = 1'b1;
        end
      end
    end
    case (mode)
      MODE_AND: res = any0 ? S_ZERO : (anyx ? S_X : S_ONE);
      MODE_OR:  res = any1 ? S_ONE : (anyx ? S_X : S_ZERO);
      default:  res = anyx ? S_X : (par ? S_ONE : S_ZERO);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rsfq_pulse_delay.sv
// Latency line and pulse stretcher: an evaluation result appears on out exactly
// DELAY cycles after it is presented, stretched to PULSE_W cycles.
module rsfq_pulse_delay
  import rsfq_gate_pkg::*;
#(
  parameter int DELAY   = 25,
  parameter int PULSE_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fire,
  input  logic x,
  output logic out,
  output logic out_x
);

  localparam int PW = $clog2(PULSE_W + 1);
  localparam logic [PW-1:0] PW_LOAD = PW'(PULSE_W);
  localparam logic [PW-1:0] PW_ONE  = PW'(1);

  logic          tap_fire;
  logic          tap_x;
  logic [PW-1:0] remain;
  logic          x_q;

  // The stretcher register itself supplies the last cycle of latency.
  generate
    if (DELAY == 1) begin : g_direct
      assign tap_fire = fire;
      assign tap_x    = x;
    end else begin : g_line
      logic line_fire [DELAY-1];
      logic line_x    [DELAY-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < DELAY - 1; j++) begin
            line_fire[j] <= 1'b0;
            line_x[j]    <= 1'b0;
          end
        end else begin
          line_fire[0] <= fire;
          line_x[0]    <= x;
          for (int j = 1; j < DELAY - 1; j++) begin
            line_fire[j] <= line_fire[j-1];
            line_x[j]    <= line_x[j-1];
          end
        end
      end

      assign tap_fire = line_fire[DELAY-2];
      assign tap_x    = line_x[DELAY-2];
    end
  endgenerate

  // A pulse arriving while the previous one continues merges its X flag in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain <= '0;
      x_q    <= 1'b0;
    end else if (tap_fire) begin
      remain <= PW_LOAD;
      x_q    <= tap_x | ((remain > PW_ONE) ? x_q : 1'b0);
    end else if (remain != '0) begin
      remain <= remain - PW_ONE;
    end
  end

  assign out   = (remain != '0);
  assign out_x = out & x_q;

endmodule

// File: rtl/rsfq_clocked_gate_n.sv
// Clocked RSFQ gate with N pulse inputs: per-channel tri-state latching,
// setup/hold violation detection and counting, delayed stretched output.
module rsfq_clocked_gate_n
  import rsfq_gate_pkg::*;
#(
  parameter int N_IN    = 2,
  parameter int MODE    = 0,
  parameter int T_HOLD  = 12,
  parameter int T_SETUP = 1,
  parameter int DELAY   = 25,
  parameter int PULSE_W = 2,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN-1:0]       in_pulse,
  input  logic                  sfq_clk,
  output logic                  out,
  output logic                  out_x,
  output logic [N_IN-1:0]       viol_pulse,
  output logic [N_IN*CNT_W-1:0] viol_cnt
);

  localparam int SW = $clog2(T_SETUP + 2);
  localparam int HW = $clog2(T_HOLD + 2);
  localparam logic [SW-1:0] SETUP_LIM = SW'(T_SETUP);
  localparam logic [HW-1:0] HOLD_LAST = HW'((T_HOLD > 0) ? T_HOLD - 1 : 0);
  localparam bit            SETUP_EN  = (T_SETUP > 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_IN-1:0]     in_prev;
  logic [N_IN-1:0]     data_edge;
  logic [N_IN-1:0]     hold_v;
  logic [N_IN-1:0]     setup_v;
  logic                sfq_prev;
  logic                clk_edge;
  logic                clk_seen;
  logic                in_hold_win;
  logic [HW-1:0]       clk_age;
  logic [SW-1:0]       data_age  [N_IN];
  tri_t                state     [N_IN];
  tri_t                data_next [N_IN];
  logic [CNT_W-1:0]    cnt_next  [N_IN];
  logic [2*MAX_IN-1:0] eval_vec;
  tri_t                result;
  logic                fire;
  logic                fire_x;

  assign data_edge   = in_pulse & ~in_prev;
  assign clk_edge    = sfq_clk & ~sfq_prev;
  assign in_hold_win = clk_seen && (clk_age != '0) && (clk_age <= HOLD_LAST);

  // Ages count cycles since the last edge (1 = previous cycle), saturating so
  // an old event never wraps back into a window.
  always_comb begin
    logic [1:0]     inc;
    logic [CNT_W:0] sum;
    hold_v   = '0;
    setup_v  = '0;
    eval_vec = '0;
    inc      = '0;
    sum      = '0;
    for (int i = 0; i < N_IN; i++) begin
      hold_v[i]  = data_edge[i] & in_hold_win;
      setup_v[i] = SETUP_EN && clk_edge && (data_edge[i] || (data_age[i] < SETUP_LIM));
      data_next[i] = hold_v[i] ? S_X : ((state[i] == S_X) ? S_X : S_ONE);
      eval_vec[2*i +: 2] = setup_v[i] ? S_X : (data_edge[i] ? data_next[i] : state[i]);
      inc = {1'b0, hold_v[i]} + {1'b0, setup_v[i]};
      sum = {1'b0, viol_cnt[i*CNT_W +: CNT_W]} + (CNT_W + 1)'(inc);
      cnt_next[i] = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    end
    result = eval_gate(MODE, eval_vec, N_IN);
    fire   = clk_edge && (result != S_ZERO);
    fire_x = clk_edge && (result == S_X);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_prev    <= '0;
      sfq_prev   <= 1'b0;
      clk_seen   <= 1'b0;
      clk_age    <= '1;
      viol_pulse <= '0;
      viol_cnt   <= '0;
      for (int i = 0; i < N_IN; i++) begin
        state[i]    <= S_ZERO;
        data_age[i] <= '1;
      end
    end else begin
      in_prev    <= in_pulse;
      sfq_prev   <= sfq_clk;
      viol_pulse <= hold_v | setup_v;
      if (clk_edge) begin
        clk_seen <= 1'b1;
        clk_age  <= HW'(1);
      end else if (clk_age != '1) begin
        clk_age <= clk_age + 1'b1;
      end
      for (int i = 0; i < N_IN; i++) begin
        viol_cnt[i*CNT_W +: CNT_W] <= cnt_next[i];
        if (data_edge[i]) begin
          data_age[i] <= SW'(1);
        end else if (data_age[i] != '1) begin
          data_age[i] <= data_age[i] + 1'b1;
        end
        // A gate clock consumes every channel; only later data can set it again.
        if (clk_edge) begin
          state[i] <= S_ZERO;
        end else if (data_edge[i]) begin
          state[i] <= data_next[i];
        end
      end
    end
  end

  rsfq_pulse_delay #(
    .DELAY  (DELAY),
    .PULSE_W(PULSE_W)
  ) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .fire (fire),
    .x    (fire_x),
    .out  (out),
    .out_x(out_x)
  );

endmodule

// File: doc/rsfq_clocked_gate_n.md
Name: rsfq_clocked_gate_n

Overview:
Cycle-based, synthesizable model of a clocked RSFQ logic gate with N pulse inputs and a parametrised logic function (AND/OR/XOR).
Every signal is modelled as a pulse: a high level on the fast sampling clock clk.
- Data pulses latch per-channel state.
- A gate-clock pulse on sfq_clk evaluates the function and clears the state.
- The result leaves as a delayed, stretched output pulse.
- Setup and hold violations are detected per channel, reported, and counted.

Parameters:
N_IN, 2, number of data channels (1..16)
MODE, 0, logic function: 0=AND, 1=OR, 2=XOR
T_HOLD, 12, hold window in clk cycles after an sfq_clk pulse (>=0)
T_SETUP, 1, setup window in clk cycles before an sfq_clk pulse (>=0)
DELAY, 25, sfq_clk-to-out latency in clk cycles (1..255)
PULSE_W, 2, output pulse width in clk cycles (>=1)
CNT_W, 8, width of each violation counter

Ports:
clk  in  1  sampling clock; all timing is in these cycles
rst_n  in  1  asynchronous active-low reset
in_pulse  in  N_IN  data pulse inputs; a rising edge is one pulse
sfq_clk  in  1  gate clock pulse input; a rising edge is one evaluation
out  out  1  output pulse
out_x  out  1  high together with out when the evaluated result is unknown
viol_pulse  out  N_IN  one-cycle flag per channel on a setup/hold violation
viol_cnt  out  N_IN*CNT_W  saturating violation counter per channel (channel i at [i*CNT_W +: CNT_W])

Behaviour:
- Reset: out, out_x, viol_pulse, viol_cnt = 0; all channel states = 0; delay line and stretcher cleared; "no clock seen" flag set.
- Asserting reset mid-operation drops every pulse in flight; no output appears after deassertion.
- Edges are detected against registered previous values. A level held high for several cycles counts as one pulse.
- Channel state has three values: 0, 1, X. Pulses at cycle t (data) and c (sfq_clk) are classified as follows:
  - Valid: no violation applies → state becomes 1. Repeated pulses keep it at 1.
  - Setup violation: data at t with c - T_SETUP < t <= c. The evaluation at c sees X for that channel, and the channel's state after c is 0.
  - If T_SETUP=0, a data pulse at t=c is valid for the evaluation at c.
  - Hold violation: data at t with c_last < t < c_last + T_HOLD, where c_last is the most recent sfq_clk pulse → state becomes X for the next evaluation.
  - Before the first sfq_clk pulse there is no hold check.
- Each violation: viol_pulse[i] is high at cycle t+1 (or c+1 for the setup case); viol_cnt[i] increments by 1 and saturates at 2^CNT_W-1.
- Evaluation at c:
  - AND: 0 if any channel is 0, else X if any is X, else 1.
  - OR: 1 if any channel is 1, else X if any is X, else 0.
  - XOR: X if any channel is X, else the parity of the states.
  - All states clear to 0 at c, except hold-window X set later.
- Output:
  - Result 1 or X → out is high for cycles c+DELAY .. c+DELAY+PULSE_W-1, with out_x=1 for X. Result 0 → no pulse.
  - If a new pulse emerges while a previous one is still active, the stretcher reloads PULSE_W and out_x is the OR of the active pulses.
  - sfq_clk pulses at most every cycle are supported. The delay line is DELAY entries of {fire, x}.
- A data pulse at t, sfq_clk at c: the pulse is valid for c if t <= c - T_SETUP.

Decomposition:
- Package rsfq_gate_pkg: mode constants (MODE_AND/OR/XOR), the 2-bit tri-state encoding (S_ZERO, S_ONE, S_X), and the eval function.
- Sub-module rsfq_pulse_delay: DELAY-deep {fire, x} shift line plus the PULSE_W stretcher driving out/out_x.

Test Plan:
1. AND, N_IN=2, defaults. in_pulse[0] at 100, in_pulse[1] at 105, sfq_clk at 120 → out=1 at cycles 145,146; out_x=0; viol_cnt=0.
2. AND. Only in_pulse[0] at 100, sfq_clk at 120 → out stays 0 through cycle 200; the following sfq_clk at 160 with no data gives no pulse (state was cleared).
3. Setup violation. in_pulse[0] at 100, in_pulse[1] at 120, sfq_clk at 120 → viol_pulse[1] at 121, viol_cnt[1]=1, out=out_x=1 at 145,146.
4. Hold violation. sfq_clk at 120, in_pulse[0] at 125 (hold), in_pulse[1] at 135 (valid), sfq_clk at 150 → viol_cnt[0]=1 at 126; out=out_x=1 at 175,176.
5. XOR, N_IN=3. Pulses on ch0 and ch2, sfq_clk at 50 → no output. Then ch0 only, sfq_clk at 80 → out at 105,106 with out_x=0. Then CNT_W=2 with 5 hold violations on ch1 → viol_cnt[1]=3.
6. Reset. Valid AND inputs, sfq_clk at 120, rst_n low at 130 for 3 cycles → no out pulse at 145; all counters 0; the first pulse after reset is not hold-checked.
